// File: rtl/i2c_xfer_sequencer_if.sv
// i2c_xfer_sequencer_if: register-block, control-buffer and byte-engine signals of the sequencer
interface i2c_xfer_sequencer_if #(parameter int CNT_W = 8);
  logic             start_req;
  logic             abort_req;
  logic [CNT_W-1:0] byte_count;
  logic [9:0]       cfg_bus_address;
  logic             cfg_data_direction;
  logic             cfg_address_mode;
  logic             cfg_stretch_enabled;
  logic [31:0]      cfg_clock_div;
  logic             bus_busy;
  logic             byte_done;
  logic             ack_error;
  logic             arb_lost;
  logic             master_idle;
  logic             load_buffer;
  logic [9:0]       u_bus_address;
  logic             u_data_direction;
  logic             u_address_mode;
  logic             u_stretch_enabled;
  logic [31:0]      u_clock_div;
  logic             master_start;
  logic             master_stop;
  logic             busy;
  logic             done;
  logic [4:0]       status;
  logic [CNT_W-1:0] bytes_left;
  modport slave (
    input  start_req, abort_req, byte_count, cfg_bus_address, cfg_data_direction,
           cfg_address_mode, cfg_stretch_enabled, cfg_clock_div, bus_busy, byte_done,
           ack_error, arb_lost, master_idle,
    output load_buffer, u_bus_address, u_data_direction, u_address_mode, u_stretch_enabled,
           u_clock_div, master_start, master_stop, busy, done, status, bytes_left
  );
  modport master (
    output start_req, abort_req, byte_count, cfg_bus_address, cfg_data_direction,
           cfg_address_mode, cfg_stretch_enabled, cfg_clock_div, bus_busy, byte_done,
           ack_error, arb_lost, master_idle,
    input  load_buffer, u_bus_address, u_data_direction, u_address_mode, u_stretch_enabled,
           u_clock_div, master_start, master_stop, busy, done, status, bytes_left
  );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: runs one I2C master transaction per start command and reports sticky status
module i2c_xfer_sequencer #(
  parameter int CNT_W     = 8,
  parameter int TO_W      = 16,
  parameter int TO_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  i2c_xfer_sequencer_if.slave b
);
  typedef enum logic [2:0] {IDLE, WAIT_BUS, LOAD, START, XFER, STOP, DONE} state_t;
  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] left_q, left_d, left_dec;
  logic [4:0]       status_q, status_d;
  logic [9:0]       addr_q, addr_d;
  logic             dir_q, dir_d, mode_q, mode_d, stretch_q, stretch_d;
  logic [31:0]      div_q, div_d;
  assign left_dec = (left_q == '0) ? '0 : left_q - CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      to_q      <= '0;
      left_q    <= '0;
      status_q  <= '0;
      addr_q    <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      stretch_q <= 1'b1;
      div_q     <= 32'd300;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      left_q    <= left_d;
      status_q  <= status_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      stretch_q <= stretch_d;
      div_q     <= div_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    left_d    = left_q;
    status_d  = status_q;
    addr_d    = addr_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    stretch_d = stretch_q;
    div_d     = div_q;
    case (state_q)
      IDLE: if (b.start_req) begin
        status_d  = (b.byte_count == '0) ? 5'b10000 : 5'b00000;
        left_d    = (b.byte_count == '0) ? left_q : b.byte_count;
        state_d   = (b.byte_count == '0) ? DONE : WAIT_BUS;
        to_d      = '0;
        addr_d    = b.cfg_bus_address;
        dir_d     = b.cfg_data_direction;
        mode_d    = b.cfg_address_mode;
        stretch_d = b.cfg_stretch_enabled;
        div_d     = b.cfg_clock_div;
      end
      WAIT_BUS: begin
        to_d = to_q + TO_W'(1);
        if (b.abort_req) begin
          status_d[2] = 1'b1;
          state_d     = DONE;
        end else if (!b.bus_busy) begin
          state_d = LOAD;
        end else if (to_q == TO_W'(TO_CYCLES - 1)) begin
          status_d[3] = 1'b1;
          state_d     = DONE;
        end
      end
      LOAD:  state_d = START;
      START: state_d = XFER;
      XFER: begin
        if (b.arb_lost) begin
          status_d[1] = 1'b1;
          status_d[2] = status_q[2] | b.abort_req;
          state_d     = DONE;
        end else if (b.ack_error) begin
          status_d[0] = 1'b1;
          left_d      = b.byte_done ? left_dec : left_q;
          state_d     = STOP;
        end else if (b.abort_req) begin
          status_d[2] = 1'b1;
          state_d     = STOP;
        end else if (b.byte_done) begin
          left_d  = left_dec;
          state_d = (left_dec == '0) ? STOP : XFER;
        end
      end
      STOP: begin
        status_d[2] = status_q[2] | b.abort_req;
        state_d     = b.master_idle ? DONE : STOP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign b.load_buffer       = state_q == LOAD;
  assign b.master_start      = state_q == START;
  assign b.master_stop       = state_q == STOP;
  assign b.done              = state_q == DONE;
  assign b.busy              = state_q != IDLE;
  assign b.status            = status_q;
  assign b.bytes_left        = left_q;
  assign b.u_bus_address     = addr_q;
  assign b.u_data_direction  = dir_q;
  assign b.u_address_mode    = mode_q;
  assign b.u_stretch_enabled = stretch_q;
  assign b.u_clock_div       = div_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer: scoreboard bench; expected loads and completions are queued at stimulus time
module tb_i2c_xfer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  int   n_load = 0;
  logic [41:0] load_q[$];
  logic [12:0] done_q[$];
  i2c_xfer_sequencer_if #(.CNT_W(8)) bus();
  i2c_xfer_sequencer #(.CNT_W(8), .TO_W(16), .TO_CYCLES(20)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] cnt, input logic [9:0] addr, input logic [31:0] div,
                          input logic mode, input logic stretch);
    bus.start_req           = 1'b1;
    bus.byte_count          = cnt;
    bus.cfg_bus_address     = addr;
    bus.cfg_clock_div       = div;
    bus.cfg_address_mode    = mode;
    bus.cfg_stretch_enabled = stretch;
    bus.cfg_data_direction  = 1'b1;
    tick();
    bus.start_req = 1'b0;
  endtask
  task automatic pulse_bd();
    bus.byte_done = 1'b1;
    tick();
    bus.byte_done = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.load_buffer) begin
      n_load++;
      if (load_q.size() == 0) chk("load_unexpected", load_q.size(), 1);
      else begin
        logic [41:0] e;
        e = load_q.pop_front();
        chk("load_addr", bus.u_bus_address, e[41:32]);
        chk("load_div", bus.u_clock_div, e[31:0]);
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_unexpected", done_q.size(), 1);
      else begin
        logic [12:0] e;
        e = done_q.pop_front();
        chk("done_status", bus.status, e[12:8]);
        chk("done_left", bus.bytes_left, e[7:0]);
      end
    end
  end
  initial begin
    int loads0;
    bus.start_req = 0; bus.abort_req = 0; bus.byte_count = 0;
    bus.cfg_bus_address = 0; bus.cfg_data_direction = 0; bus.cfg_address_mode = 0;
    bus.cfg_stretch_enabled = 0; bus.cfg_clock_div = 0;
    bus.bus_busy = 0; bus.byte_done = 0; bus.ack_error = 0; bus.arb_lost = 0; bus.master_idle = 0;
    tick(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_left", bus.bytes_left, 0);
    chk("rst_stretch", bus.u_stretch_enabled, 1);
    chk("rst_div", bus.u_clock_div, 300);
    chk("rst_addr", bus.u_bus_address, 0);
    rst = 1'b0;
    tick();
    // normal 3-byte TX
    load_q.push_back({10'h02A, 32'd100});
    done_q.push_back({5'b00000, 8'd0});
    do_start(8'd3, 10'h02A, 32'd100, 1'b0, 1'b1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_noload", bus.load_buffer, 0);
    tick();
    chk("t1_load", bus.load_buffer, 1);
    chk("t1_mstart_early", bus.master_start, 0);
    tick();
    chk("t1_mstart", bus.master_start, 1);
    tick();
    pulse_bd(); tick(); pulse_bd();
    chk("t1_left1", bus.bytes_left, 1);
    chk("t1_nostop", bus.master_stop, 0);
    pulse_bd();
    chk("t1_stop", bus.master_stop, 1);
    chk("t1_left0", bus.bytes_left, 0);
    tick();
    chk("t1_stop_hold", bus.master_stop, 1);
    bus.master_idle = 1'b1;
    tick();
    bus.master_idle = 1'b0;
    chk("t1_done", bus.done, 1);
    chk("t1_stop_drop", bus.master_stop, 0);
    chk("t1_done_busy", bus.busy, 1);
    tick();
    chk("t1_idle", bus.busy, 0);
    chk("t1_done_pulse", bus.done, 0);
    // busy bus then timeout
    loads0 = n_load;
    bus.bus_busy = 1'b1;
    done_q.push_back({5'b01000, 8'd2});
    do_start(8'd2, 10'h011, 32'd9, 1'b0, 1'b1);
    tick(19);
    chk("t2_not_yet", bus.done, 0);
    tick();
    chk("t2_done", bus.done, 1);
    chk("t2_noload", n_load, loads0);
    bus.bus_busy = 1'b0;
    tick();
    // NACK on byte 2 of 4, together with byte_done
    load_q.push_back({10'h155, 32'd7});
    done_q.push_back({5'b00001, 8'd2});
    do_start(8'd4, 10'h155, 32'd7, 1'b1, 1'b0);
    tick(3);
    chk("t3_mode", bus.u_address_mode, 1);
    pulse_bd();
    bus.byte_done = 1'b1; bus.ack_error = 1'b1;
    tick();
    bus.byte_done = 1'b0; bus.ack_error = 1'b0;
    chk("t3_stop", bus.master_stop, 1);
    chk("t3_left", bus.bytes_left, 2);
    bus.master_idle = 1'b1;
    tick();
    bus.master_idle = 1'b0;
    tick();
    // arbitration lost with abort
    load_q.push_back({10'h3C1, 32'd1234});
    done_q.push_back({5'b00110, 8'd5});
    do_start(8'd6, 10'h3C1, 32'd1234, 1'b0, 1'b1);
    tick(3);
    pulse_bd();
    bus.arb_lost = 1'b1; bus.abort_req = 1'b1;
    tick();
    bus.arb_lost = 1'b0; bus.abort_req = 1'b0;
    chk("t4_done", bus.done, 1);
    chk("t4_nostop", bus.master_stop, 0);
    tick();
    // zero length; start_req in DONE dropped
    loads0 = n_load;
    done_q.push_back({5'b10000, 8'd5});
    bus.start_req = 1'b1; bus.byte_count = 8'd0;
    tick();
    chk("t5_done", bus.done, 1);
    bus.byte_count = 8'd3;
    tick();
    bus.start_req = 1'b0;
    chk("t5_idle", bus.busy, 0);
    chk("t5_status", bus.status, 5'b10000);
    chk("t5_noload", n_load, loads0);
    // start_req while busy ignored; abort beats bus going free
    bus.bus_busy = 1'b1;
    done_q.push_back({5'b00100, 8'd3});
    do_start(8'd3, 10'h077, 32'd50, 1'b0, 1'b1);
    bus.start_req = 1'b1; bus.byte_count = 8'd9;
    tick(2);
    bus.start_req = 1'b0;
    chk("t5_left_kept", bus.bytes_left, 3);
    bus.abort_req = 1'b1; bus.bus_busy = 1'b0;
    tick();
    bus.abort_req = 1'b0;
    chk("t5_abort_done", bus.done, 1);
    tick(2);
    chk("t5_noload2", n_load, loads0);
    // reset mid-XFER
    load_q.push_back({10'h200, 32'd55});
    do_start(8'd5, 10'h200, 32'd55, 1'b0, 1'b0);
    tick(3);
    chk("t6_left", bus.bytes_left, 5);
    chk("t6_stretch0", bus.u_stretch_enabled, 0);
    rst = 1'b1;
    tick();
    chk("t6_busy", bus.busy, 0);
    chk("t6_stop", bus.master_stop, 0);
    chk("t6_stretch", bus.u_stretch_enabled, 1);
    chk("t6_div", bus.u_clock_div, 300);
    chk("t6_status", bus.status, 0);
    chk("t6_left0", bus.bytes_left, 0);
    rst = 1'b0;
    tick(2);
    chk("sb_load_left", load_q.size(), 0);
    chk("sb_done_left", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
